pc_fetch_unit: RTL and testbench

Program-counter and fetch-sequencing stage of the picoMIPS core. Holds the registered instruction address that drives the program memory's `addressIn` and computes the next address from sequential increment, relative branch, absolute jump, and subroutine call/return via a small hardware return-address stack. Program memory reads asynchronously, so the instruction for `addressOut` is available in the same cycle. The decoder uses that instruction to drive this block's control inputs for the next edge.

---
 rtl/pc_pkg.sv | 16 +
 rtl/return_stack.sv | 65 ++++++
 rtl/pc_fetch_unit.sv | 134 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types for the picoMIPS fetch stage: default address type and next-PC select codes.
package pc_pkg;

    localparam int P_SIZE = 5;

    typedef logic [P_SIZE-1:0] address_t;

    typedef enum logic [2:0] {
        PC_INC,
        PC_BRANCH,
        PC_JUMP,
        PC_CALL,
        PC_RETURN
    } pc_sel_t;

endpackage

// File: rtl/return_stack.sv
// Circular LIFO of return addresses. A push when full overwrites the oldest entry;
// a pop when empty is ignored. Pop takes precedence if both are requested.
module return_stack
    import pc_pkg::*;
#(
    parameter int WIDTH       = P_SIZE,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               push,
    input  logic                               pop,
    input  logic [WIDTH-1:0]                   push_data,
    output logic [WIDTH-1:0]                   top_data,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               full,
    output logic                               empty
);

    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(STACK_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(STACK_DEPTH);

    logic [WIDTH-1:0] mem [STACK_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] next_ptr;
    logic [PTR_W-1:0] top_ptr;
    logic [CNT_W-1:0] count;

    // wr_ptr names the next free slot, so once full it also points at the oldest entry.
    always_comb begin
        next_ptr = (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + PTR_W'(1);
        top_ptr  = (wr_ptr == '0) ? LAST_SLOT : wr_ptr - PTR_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (pop) begin
            if (!empty) begin
                wr_ptr <= top_ptr;
                count  <= count - CNT_W'(1);
            end
        end else if (push) begin
            wr_ptr <= next_ptr;
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !pop) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign top_data = mem[top_ptr];
    assign depth    = count;
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and next-address selection for the picoMIPS fetch stage.
// Define PC_RETURN_STACK_EN to build the call/return stack; otherwise call acts as jump.
module pc_fetch_unit #(
    parameter int P_SIZE      = 5,
    parameter int STACK_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enableIn,
    input  logic                             branchIn,
    input  logic [P_SIZE-1:0]                offsetIn,
    input  logic                             jumpIn,
    input  logic                             callIn,
    input  logic                             returnIn,
    input  logic [P_SIZE-1:0]                targetIn,
    output logic [P_SIZE-1:0]                addressOut,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stackDepthOut,
    output logic                             stackOverflowOut,
    output logic                             stackUnderflowOut
);

    import pc_pkg::*;

    localparam int CNT_W = $clog2(STACK_DEPTH + 1);

    logic [P_SIZE-1:0] pc;
    logic [P_SIZE-1:0] pc_inc;
    logic [P_SIZE-1:0] pc_branch;
    logic [P_SIZE-1:0] pc_next;
    pc_sel_t           sel;

    assign pc_inc    = pc + P_SIZE'(1);
    // A same-width add is the two's-complement sum modulo 2^P_SIZE, so no explicit sign extension.
    assign pc_branch = pc + offsetIn;

`ifdef PC_RETURN_STACK_EN
    logic [P_SIZE-1:0] stack_top;
    logic [CNT_W-1:0]  stack_depth;
    logic              stack_full;
    logic              stack_empty;
    logic              do_push;
    logic              do_pop;
    logic              overflow;
    logic              underflow;

    always_comb begin
        sel = PC_INC;
        if (returnIn) begin
            sel = PC_RETURN;
        end else if (callIn) begin
            sel = PC_CALL;
        end else if (jumpIn) begin
            sel = PC_JUMP;
        end else if (branchIn) begin
            sel = PC_BRANCH;
        end
    end

    assign do_push = enableIn && (sel == PC_CALL);
    assign do_pop  = enableIn && (sel == PC_RETURN);

    return_stack #(
        .WIDTH      (P_SIZE),
        .STACK_DEPTH(STACK_DEPTH)
    ) u_return_stack (
        .clk      (clk),
        .reset    (reset),
        .push     (do_push),
        .pop      (do_pop),
        .push_data(pc_inc),
        .top_data (stack_top),
        .depth    (stack_depth),
        .full     (stack_full),
        .empty    (stack_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_push && stack_full) begin
                overflow <= 1'b1;
            end
            if (do_pop && stack_empty) begin
                underflow <= 1'b1;
            end
        end
    end

    assign stackDepthOut     = stack_depth;
    assign stackOverflowOut  = overflow;
    assign stackUnderflowOut = underflow;
`else
    logic unused_return;
    assign unused_return = returnIn;

    always_comb begin
        sel = PC_INC;
        if (callIn || jumpIn) begin
            sel = PC_JUMP;
        end else if (branchIn) begin
            sel = PC_BRANCH;
        end
    end

    assign stackDepthOut     = '0;
    assign stackOverflowOut  = 1'b0;
    assign stackUnderflowOut = 1'b0;
`endif

    always_comb begin
        case (sel)
            PC_BRANCH: pc_next = pc_branch;
            PC_JUMP:   pc_next = targetIn;
`ifdef PC_RETURN_STACK_EN
            PC_CALL:   pc_next = targetIn;
            PC_RETURN: pc_next = stack_empty ? pc_inc : stack_top;
`endif
            default:   pc_next = pc_inc;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= '0;
        end else if (enableIn) begin
            pc <= pc_next;
        end
    end

    assign addressOut = pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed table, multi-cycle stack sequences, async reset,
// and randomized traffic against a queue-based reference model. Follows PC_RETURN_STACK_EN.
module tb_pc_fetch_unit;

    import pc_pkg::*;

    localparam int STACK_DEPTH = 4;
`ifdef PC_RETURN_STACK_EN
    localparam bit STACK_EN = 1'b1;
`else
    localparam bit STACK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       enableIn;
    logic       branchIn;
    logic [4:0] offsetIn;
    logic       jumpIn;
    logic       callIn;
    logic       returnIn;
    logic [4:0] targetIn;
    logic [4:0] addressOut;
    logic [2:0] stackDepthOut;
    logic       stackOverflowOut;
    logic       stackUnderflowOut;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .P_SIZE     (5),
        .STACK_DEPTH(STACK_DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enableIn         (enableIn),
        .branchIn         (branchIn),
        .offsetIn         (offsetIn),
        .jumpIn           (jumpIn),
        .callIn           (callIn),
        .returnIn         (returnIn),
        .targetIn         (targetIn),
        .addressOut       (addressOut),
        .stackDepthOut    (stackDepthOut),
        .stackOverflowOut (stackOverflowOut),
        .stackUnderflowOut(stackUnderflowOut)
    );

    typedef struct {
        logic       en;
        logic       br;
        logic [4:0] off;
        logic       jmp;
        logic       cal;
        logic       ret;
        logic [4:0] tgt;
        int         exp_pc;
        int         exp_depth;
    } vec_t;

    vec_t     vecs[11];
    int       checks = 0;
    int       errors = 0;

    // Reference model: PC as an integer, return stack as a queue (newest at the back).
    address_t m_pc;
    address_t m_q[$];
    bit       m_ovf;
    bit       m_unf;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name, input int exp_pc, input int exp_depth,
                               input int exp_ovf, input int exp_unf);
        check({name, "_pc"}, int'(addressOut), exp_pc);
        check({name, "_depth"}, int'(stackDepthOut), exp_depth);
        check({name, "_ovf"}, int'(stackOverflowOut), exp_ovf);
        check({name, "_unf"}, int'(stackUnderflowOut), exp_unf);
    endtask

    task automatic applyStimulus(input logic en, input logic br, input logic [4:0] off,
                                 input logic jmp, input logic cal, input logic ret,
                                 input logic [4:0] tgt);
        enableIn = en;
        branchIn = br;
        offsetIn = off;
        jumpIn   = jmp;
        callIn   = cal;
        returnIn = ret;
        targetIn = tgt;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic modelStep(input logic en, input logic br, input logic [4:0] off,
                             input logic jmp, input logic cal, input logic ret,
                             input logic [4:0] tgt);
        int inc;
        inc = (int'(m_pc) + 1) % 32;
        if (!en) return;
        if (STACK_EN && ret) begin
            if (m_q.size() > 0) begin
                m_pc = m_q.pop_back();
            end else begin
                m_pc  = address_t'(inc);
                m_unf = 1'b1;
            end
        end else if (STACK_EN && cal) begin
            if (m_q.size() == STACK_DEPTH) begin
                m_q.delete(0);
                m_ovf = 1'b1;
            end
            m_q.push_back(address_t'(inc));
            m_pc = tgt;
        end else if (cal || jmp) begin
            m_pc = tgt;
        end else if (br) begin
            m_pc = address_t'(((int'(m_pc) + int'($signed(off))) % 32 + 32) % 32);
        end else begin
            m_pc = address_t'(inc);
        end
    endtask

    initial begin
        reset    = 1'b1;
        enableIn = 1'b0;
        branchIn = 1'b0;
        offsetIn = '0;
        jumpIn   = 1'b0;
        callIn   = 1'b0;
        returnIn = 1'b0;
        targetIn = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("reset", 0, 0, 0, 0);

        for (int i = 0; i < 33; i++) begin
            idle();
            check($sformatf("inc%0d", i), int'(addressOut), (i + 1) % 32);
        end
        applyStimulus(1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1, 5'd17);
        checkOutput("stall", 1, 0, 0, 0);

        vecs[0]  = '{1'b1, 1'b0, 5'd0,      1'b1, 1'b0, 1'b0, 5'd10, 10, 0};
        vecs[1]  = '{1'b1, 1'b1, 5'b11101,  1'b0, 1'b0, 1'b0, 5'd0,  7,  0};
        vecs[2]  = '{1'b1, 1'b0, 5'd0,      1'b1, 1'b0, 1'b0, 5'd30, 30, 0};
        vecs[3]  = '{1'b1, 1'b1, 5'd4,      1'b0, 1'b0, 1'b0, 5'd0,  2,  0};
        vecs[4]  = '{1'b1, 1'b1, 5'd0,      1'b0, 1'b0, 1'b0, 5'd0,  2,  0};
        vecs[5]  = '{1'b1, 1'b0, 5'd0,      1'b1, 1'b0, 1'b0, 5'd3,  3,  0};
        vecs[6]  = '{1'b1, 1'b1, 5'd7,      1'b1, 1'b1, 1'b0, 5'd20, 20, STACK_EN ? 1 : 0};
        vecs[7]  = '{1'b1, 1'b0, 5'd0,      1'b0, 1'b0, 1'b1, 5'd0,  STACK_EN ? 4 : 21, 0};
        vecs[8]  = '{1'b1, 1'b0, 5'd0,      1'b0, 1'b1, 1'b0, 5'd12, 12, STACK_EN ? 1 : 0};
        vecs[9]  = '{1'b1, 1'b0, 5'd0,      1'b0, 1'b0, 1'b1, 5'd0,  STACK_EN ? 5 : 13, 0};
        vecs[10] = '{1'b0, 1'b0, 5'd0,      1'b1, 1'b0, 1'b0, 5'd9,  STACK_EN ? 5 : 13, 0};
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].en, vecs[i].br, vecs[i].off, vecs[i].jmp,
                          vecs[i].cal, vecs[i].ret, vecs[i].tgt);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_depth, 0, 0);
        end

        if (STACK_EN) begin
            applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd1);
            for (int i = 2; i <= 5; i++) begin
                applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'(i));
                checkOutput($sformatf("nest%0d", i), i, i - 1, 0, 0);
            end
            applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd9);
            checkOutput("overflow_call", 9, 4, 1, 0);
            for (int i = 0; i < 4; i++) begin
                applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0);
                checkOutput($sformatf("unwind%0d", i), 6 - i, 3 - i, 1, 0);
            end
            applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0);
            checkOutput("underflow_ret", 4, 0, 1, 1);
            applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd17);
            checkOutput("call17", 17, 1, 1, 1);
            applyStimulus(1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd22);
            checkOutput("ret_beats_call", 5, 0, 1, 1);
        end

        applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd14);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd16);
        check("pre_reset_pc", int'(addressOut), 16);
        check("pre_reset_depth", int'(stackDepthOut), STACK_EN ? 2 : 0);
        callIn   = 1'b1;
        targetIn = 5'd9;
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset", 0, 0, 0, 0);
        callIn = 1'b0;
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("post_reset", 1, 0, 0, 0);

        m_pc  = 5'd1;
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        for (int i = 0; i < 300; i++) begin
            logic       en, br, jmp, cal, ret;
            logic [4:0] off, tgt;
            en  = ($urandom_range(0, 9) != 0);
            br  = ($urandom_range(0, 3) == 0);
            jmp = ($urandom_range(0, 5) == 0);
            cal = ($urandom_range(0, 4) == 0);
            ret = ($urandom_range(0, 4) == 0);
            off = 5'($urandom);
            tgt = 5'($urandom);
            modelStep(en, br, off, jmp, cal, ret, tgt);
            applyStimulus(en, br, off, jmp, cal, ret, tgt);
            checkOutput($sformatf("rand%0d", i), int'(m_pc), m_q.size(), int'(m_ovf), int'(m_unf));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
